// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: instruction fetch stage. Holds the PC, issues sequential
// fetch requests to instruction memory, and buffers returned words in a small
// in-order queue for decode. Redirects restart fetch and flush the queue.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect sets sticky misalign_err and halts fetch
//   undefined : redirect_pc[1:0] is forced to 2'b00 and the FSM never halts
//
// Handshakes (both strict valid/ready):
//   fetch  : transfer when imem_req && imem_ack; imem_req never depends on
//            imem_ack, and once raised it holds with a stable imem_addr until
//            acked (only redirect or rst withdraw it).
//   decode : transfer when inst_valid && inst_ready; inst_valid never depends
//            on inst_ready, and inst/inst_pc hold until consumed.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        misalign_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q;
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   addr_mem [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          redirect_take;
  logic          enq, deq;
  logic [31:0]   redirect_target;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic          misalign;
  logic          err_q;
`endif

  // Request and queue-handshake decode; redirect is ignored while halted.
  always_comb begin
    redirect_take = redirect && (state_q == RUN);
    imem_req      = !rst && !redirect && (state_q == RUN) && (count_q < DEPTH_C);
    enq           = imem_req && imem_ack;
    inst_valid    = (count_q != '0);
    deq           = inst_valid && inst_ready;
    inst          = data_mem[head_q];
    inst_pc       = addr_mem[head_q];
    imem_addr     = pc_q;
    pc_plus4      = pc_q + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign        = (redirect_pc[1:0] != 2'b00);
    redirect_target = redirect_pc;
    misalign_err    = err_q;
`else
    redirect_target = redirect_pc & 32'hFFFF_FFFC;
    misalign_err    = 1'b0;
`endif
  end

  // FSM next state: only a misaligned redirect (trap build) leaves RUN.
  always_comb begin
    state_d = state_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (redirect_take && misalign) begin
      state_d = HALT;
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (redirect_take && misalign) begin
      err_q <= 1'b1;
    end
  end
`endif

  // Program counter: redirect wins, otherwise advance on each accepted fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_take) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (!misalign) begin
        pc_q <= redirect_target;
      end
`else
      pc_q <= redirect_target;
`endif
    end else if (enq) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // Instruction queue: circular buffer, flushed by redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else if (redirect_take) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        data_mem[tail_q] <= imem_rdata;
        addr_mem[tail_q] <= pc_q;
        tail_q           <= tail_q + PW'(1);
      end
      if (deq) begin
        head_q <= head_q + PW'(1);
      end
      if (enq && !deq) begin
        count_q <= count_q + CW'(1);
      end else if (deq && !enq) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: directed scenarios plus a randomized run against a
// queue-based behavioural model of the fetch stage.
module tb_pc_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        misalign_err;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  pc_fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc_plus4(pc_plus4), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .misalign_err(misalign_err)
  );

  // ---------------- reference model ----------------
  // exp_q holds {pc, instruction} of each buffered word, oldest first.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc   = RESET_PC;
  bit          m_halt = 1'b0;
  bit          m_err  = 1'b0;

  function automatic bit exp_req();
    return !rst && !redirect && !m_halt && (exp_q.size() < DEPTH);
  endfunction

  always @(posedge clk) begin
    bit do_enq, do_deq;
    if (rst) begin
      m_pc = RESET_PC;
      exp_q.delete();
      m_halt = 1'b0;
      m_err  = 1'b0;
    end else if (redirect && !m_halt) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc % 4 != 0) begin
        m_err  = 1'b1;
        m_halt = 1'b1;
      end else begin
        m_pc = redirect_pc;
      end
`else
      m_pc = (redirect_pc / 4) * 4;
`endif
      exp_q.delete();
    end else begin
      do_enq = imem_ack && !m_halt && (exp_q.size() < DEPTH);
      do_deq = inst_ready && (exp_q.size() != 0);
      if (do_deq) void'(exp_q.pop_front());
      if (do_enq) begin
        exp_q.push_back({m_pc, imem_rdata});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Apply one cycle of inputs on the falling edge; outputs settle 1 ns later.
  task automatic drive(input logic r, input logic rd, input logic [31:0] rpc,
                       input logic ack, input logic [31:0] data, input logic rdy);
    @(negedge clk);
    rst = r; redirect = rd; redirect_pc = rpc;
    imem_ack = ack; imem_rdata = data; inst_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    vectors++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RESET_PC); end
    vectors++; if (pc_plus4 !== RESET_PC + 32'd4) begin errors++; $display("FAIL reset_pc4: got %h expected %h", pc_plus4, RESET_PC + 32'd4); end
    vectors++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    vectors++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL reset_head: got %h/%h expected 0/0", inst, inst_pc); end
    vectors++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", misalign_err); end
  endtask

  task automatic test_stream();
    do_reset();
    drive(1'b0, 1'b0, '0, 1'b1, 32'h0000_0013, 1'b1);
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stream_first_req: got %b/%h expected 1/0", imem_req, imem_addr); end
    vectors++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %b expected 0", inst_valid); end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 32'h0000_0013, 1'b1);
      vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k) || inst !== 32'h0000_0013) begin
        errors++; $display("FAIL stream_head%0d: got %b/%h/%h expected 1/%h/00000013", k, inst_valid, inst_pc, inst, 32'(4 * k));
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    drive(1'b0, 1'b0, '0, 1'b1, 32'h1111_0000, 1'b0);
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL full_c0: got %b/%h expected 1/0", imem_req, imem_addr); end
    drive(1'b0, 1'b0, '0, 1'b1, 32'h1111_0004, 1'b0);
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL full_c1: got %b/%h expected 1/4", imem_req, imem_addr); end
    drive(1'b0, 1'b0, '0, 1'b1, 32'h1111_0008, 1'b0);
    vectors++; if (imem_req !== 1'b0 || imem_addr !== 32'h8) begin errors++; $display("FAIL full_stall: got %b/%h expected 0/8", imem_req, imem_addr); end
    drive(1'b0, 1'b0, '0, 1'b1, 32'h1111_0008, 1'b1);
    vectors++; if (imem_req !== 1'b0 || inst_pc !== 32'h0 || inst !== 32'h1111_0000) begin errors++; $display("FAIL full_drain0: got %b/%h/%h expected 0/0/11110000", imem_req, inst_pc, inst); end
    drive(1'b0, 1'b0, '0, 1'b1, 32'h1111_0008, 1'b1);
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || inst_pc !== 32'h4 || inst !== 32'h1111_0004) begin
      errors++; $display("FAIL full_drain4: got %b/%h/%h/%h expected 1/8/4/11110004", imem_req, imem_addr, inst_pc, inst);
    end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst !== 32'h1111_0008) begin errors++; $display("FAIL full_resume: got %b/%h/%h expected 1/8/11110008", inst_valid, inst_pc, inst); end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(1'b0, 1'b0, '0, 1'b1, 32'hAAAA_0000, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 32'hAAAA_0004, 1'b0);
    drive(1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 1'b0);
    vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req_drop: got %b expected 0", imem_req); end
    drive(1'b0, 1'b0, '0, 1'b1, 32'h0000_0ABC, 1'b1);
    vectors++; if (inst_valid !== 1'b0 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin
      errors++; $display("FAIL redir_next: got %b/%h/%b expected 0/100/1", inst_valid, imem_addr, imem_req);
    end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== 32'h0000_0ABC) begin
      errors++; $display("FAIL redir_first: got %b/%h/%h expected 1/100/00000abc", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 32'h5555_5555, 1'b1);
    vectors++; if (imem_addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_top: got %h/%h expected fffffffc/0", imem_addr, pc_plus4); end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    vectors++; if (imem_addr !== 32'h0 || inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_zero: got %h/%h expected 0/fffffffc", imem_addr, inst_pc); end
  endtask

  task automatic test_misalign();
    do_reset();
    drive(1'b0, 1'b1, 32'h0000_0102, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, '0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
    vectors++; if (misalign_err !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL misalign_trap: got %b/%b expected 1/0", misalign_err, imem_req); end
    drive(1'b0, 1'b1, 32'h0000_0200, 1'b1, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1, '0, 1'b1);
    vectors++; if (imem_req !== 1'b0 || imem_addr !== RESET_PC || misalign_err !== 1'b1) begin
      errors++; $display("FAIL misalign_halt: got %b/%h/%b expected 0/%h/1", imem_req, imem_addr, misalign_err, RESET_PC);
    end
`else
    vectors++; if (imem_addr !== 32'h0000_0100 || misalign_err !== 1'b0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL misalign_mask: got %h/%b/%b expected 100/0/1", imem_addr, misalign_err, imem_req);
    end
`endif
  endtask

  task automatic test_rst_redirect();
    do_reset();
    drive(1'b0, 1'b0, '0, 1'b1, 32'h7777_0000, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 32'h7777_0004, 1'b0);
    drive(1'b1, 1'b1, 32'h0000_0300, 1'b1, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    vectors++; if (imem_addr !== RESET_PC || inst_valid !== 1'b0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL rst_over_redirect: got %h/%b/%b expected %h/0/1", imem_addr, inst_valid, imem_req, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 11) == 0, rpc,
            $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
      vectors++; if (imem_req !== exp_req()) begin errors++; $display("FAIL rand_req @%0d: got %b expected %b", n, imem_req, exp_req()); end
      vectors++; if (imem_addr !== m_pc || pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rand_pc @%0d: got %h/%h expected %h", n, imem_addr, pc_plus4, m_pc); end
      vectors++; if (inst_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rand_valid @%0d: got %b expected %0d entries", n, inst_valid, exp_q.size()); end
      vectors++; if (misalign_err !== m_err) begin errors++; $display("FAIL rand_err @%0d: got %b expected %b", n, misalign_err, m_err); end
      if (exp_q.size() != 0) begin
        vectors++; if ({inst_pc, inst} !== exp_q[0]) begin errors++; $display("FAIL rand_head @%0d: got %h/%h expected %h", n, inst_pc, inst, exp_q[0]); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_wrap();
    test_misalign();
    test_rst_redirect();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
